// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_fsm
//  Purpose  : Multi-cycle control sequencer for the MIPS-16 datapath. Walks
//             each instruction through fetch / decode / execute / memory /
//             writeback over one shared ALU and one unified memory port.
//             Includes a memory wait-state watchdog, a sticky trap flag and an
//             instruction retire counter.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          : clock, synchronous active-high reset
//    run               : permits a new fetch to start
//    opcode, funct     : IR[15:12] and IR[2:0]
//    zero              : ALU zero flag (branch condition)
//    mem_ready         : memory completes the current access this cycle
//    mem_req, mem_we   : memory request and write qualifier
//    iord              : address select (0 PC, 1 ALUOut)
//    ir_write, pc_en   : IR load, PC load enables
//    pc_src            : PC source (0 ALU result, 1 ALUOut)
//    alu_src_a/b       : ALU operand selects
//    alu_ctrl          : ALU operation
//    reg_dst           : destination register select (1 rd, 0 rt)
//    mem_to_reg        : writeback source (1 MDR, 0 ALUOut)
//    reg_write         : register file write enable
//    trap              : sticky error flag
//    state             : current state (debug)
//    retire_cnt        : instructions completed
// ============================================================================
module mc_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int RETIRE_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [3:0]          opcode,
  input  logic [2:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_en,
  output logic                pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_ctrl,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                trap,
  output logic [3:0]          state,
  output logic [RETIRE_W-1:0] retire_cnt
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WB   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_WB_ALU   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_SUBI = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1100;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // Count value at which one more unanswered request cycle means timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  logic [3:0]          state_q, state_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                trap_q, trap_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;

  logic req_active;
  logic wait_expired;
  logic retire_now;

  // A request is outstanding in fetch (only when run) and both data states.
  assign req_active   = ((state_q == S_FETCH) && run) ||
                        (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Completion beats the timeout when mem_ready arrives on the last cycle.
  assign wait_expired = req_active && !mem_ready && (wait_cnt_q == WAIT_LAST);
  assign retire_now   = (state_q == S_WB_ALU) || (state_q == S_MEM_WB) ||
                        (state_q == S_BRANCH) ||
                        ((state_q == S_MEM_WR) && mem_ready);

  assign state      = state_q;
  assign trap       = trap_q;
  assign retire_cnt = retire_q;

  // --------------------------------------------------------------------------
  // State register and bookkeeping flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      trap_q     <= 1'b0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      trap_q     <= trap_d;
      retire_q   <= retire_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          if (mem_ready)         state_d = S_DECODE;
          else if (wait_expired) state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:            state_d = S_EXEC_R;
          OP_ADDI, OP_SUBI: state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          default:         state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_WB_ALU:           state_d = S_FETCH;
      // Only lw/sw reach here, so anything other than lw is a store.
      S_MEM_ADDR:         state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)         state_d = S_MEM_WB;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_MEM_WB:           state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)         state_d = S_FETCH;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_BRANCH:           state_d = S_FETCH;
      S_TRAP:             state_d = S_TRAP;
      default:            state_d = S_TRAP;
    endcase
  end

  // --------------------------------------------------------------------------
  // Watchdog, trap and retire next values
  // --------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    // Any state change restarts the count, which covers entry into each
    // requesting state; run=0 in fetch leaves the count untouched.
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (req_active && !mem_ready)
      wait_cnt_d = wait_cnt_q + 8'd1;

    trap_d   = trap_q || (state_d == S_TRAP);
    retire_d = retire_q + {{(RETIRE_W-1){1'b0}}, retire_now};
  end

  // --------------------------------------------------------------------------
  // Output logic (Moore, except the fetch completion and branch enable)
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          if (run) begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_en    = 1'b1;
            end
          end
        end
        S_DECODE: begin
          // PC + sign-ext offset lands in ALUOut as the branch target.
          alu_src_b = 2'b10;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_ctrl  = funct;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_R);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_src    = 1'b1;
          pc_en     = zero;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl_fsm
//  Purpose  : Self-checking bench for mc_ctrl_fsm. Instructions are issued
//             with random wait states; an instruction-level model predicts
//             latency, visited states and side effects, and a monitor compares
//             at each retirement. Directed cases cover reset, trap and the
//             watchdog limit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_fsm;

  localparam int MEM_WAIT_MAX = 15;
  localparam int RETIRE_W     = 16;

  logic clk = 1'b0;
  logic rst, run, zero, mem_ready;
  logic [3:0] opcode;
  logic [2:0] funct;
  logic mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic reg_dst, mem_to_reg, reg_write, trap;
  logic [3:0] state;
  logic [RETIRE_W-1:0] retire_cnt;

  mc_ctrl_fsm #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .RETIRE_W(RETIRE_W)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .trap(trap), .state(state), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    int          cycles;
    logic [31:0] seq;
    int          regw;
    logic        rdst;
    logic        m2r;
    int          wr;
    int          rd;
    int          irw;
    int          brs;
    logic [2:0]  alu;
    logic [15:0] rc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_rc;
  int          wf_g, wd_g, req_cnt;
  bit          mon_en;

  // Monitor accumulators for the instruction in flight
  int          a_cyc, a_regw, a_wr, a_rd, a_irw, a_brs;
  logic [31:0] a_seq;
  logic [3:0]  a_last;
  logic        a_rdst, a_m2r;
  logic [2:0]  a_alu;
  logic [15:0] last_rc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void acc_clear();
    a_cyc = 0; a_regw = 0; a_wr = 0; a_rd = 0; a_irw = 0; a_brs = 0;
    a_seq = '0; a_last = 4'hF; a_rdst = 1'b0; a_m2r = 1'b0; a_alu = 3'b000;
  endfunction

  // Instruction-level reference: latency from the published cycle counts plus
  // wait states, the states an instruction visits, and its side effects.
  function automatic exp_t model(input logic [3:0] op, input logic [2:0] fn,
                                 input logic z, input int wf, input int wd,
                                 input logic [15:0] rc);
    exp_t e;
    e.op = op; e.regw = 0; e.rdst = 1'b0; e.m2r = 1'b0; e.wr = 0; e.rd = 0;
    e.irw = 1; e.brs = 0; e.rc = rc;
    case (op)
      4'b0000: begin e.cycles = 4 + wf; e.seq = 32'h0129; e.regw = 1; e.rdst = 1'b1; e.alu = fn; end
      4'b0001: begin e.cycles = 4 + wf; e.seq = 32'h0139; e.regw = 1; e.alu = 3'b010; end
      4'b0010: begin e.cycles = 4 + wf; e.seq = 32'h0139; e.regw = 1; e.alu = 3'b110; end
      4'b1000: begin e.cycles = 5 + wf + wd; e.seq = 32'h01456; e.regw = 1; e.m2r = 1'b1; e.rd = 1; e.alu = 3'b010; end
      4'b1010: begin e.cycles = 4 + wf + wd; e.seq = 32'h0147; e.wr = 1; e.alu = 3'b010; end
      default: begin e.cycles = 3 + wf; e.seq = 32'h018; e.brs = z ? 1 : 0; e.alu = 3'b110; end
    endcase
    return e;
  endfunction

  // Monitor: pops an expectation whenever the retire counter moves.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!mon_en) begin
      acc_clear();
      last_rc = retire_cnt;
    end else begin
      if (retire_cnt !== last_rc) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_retire: got retire_cnt %0h with nothing expected", retire_cnt);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("cycles op=%b", e.op), 32'(a_cyc), 32'(e.cycles));
          chk($sformatf("state_trace op=%b", e.op), a_seq, e.seq);
          chk("reg_write_cnt", 32'(a_regw), 32'(e.regw));
          chk("reg_dst", 32'(a_rdst), 32'(e.rdst));
          chk("mem_to_reg", 32'(a_m2r), 32'(e.m2r));
          chk("mem_write_cnt", 32'(a_wr), 32'(e.wr));
          chk("mem_read_cnt", 32'(a_rd), 32'(e.rd));
          chk("ir_write_cnt", 32'(a_irw), 32'(e.irw));
          chk("branch_pc_cnt", 32'(a_brs), 32'(e.brs));
          chk($sformatf("alu_ctrl op=%b", e.op), 32'(a_alu), 32'(e.alu));
          chk("retire_cnt", 32'(retire_cnt), 32'(e.rc));
        end
        acc_clear();
        last_rc = retire_cnt;
      end
      if (state != 4'd0 || mem_req) begin
        a_cyc++;
        if (state !== a_last) begin
          a_seq  = {a_seq[27:0], state};
          a_last = state;
        end
        if (reg_write) begin a_regw++; a_rdst = reg_dst; a_m2r = mem_to_reg; end
        if (mem_req && mem_ready && mem_we) a_wr++;
        if (mem_req && mem_ready && iord && !mem_we) a_rd++;
        if (ir_write) a_irw++;
        if (pc_en && pc_src) a_brs++;
        if (alu_src_a) a_alu = alu_ctrl;
      end
      if (state == 4'd0 && !run) chk("idle_no_req", 32'(mem_req), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: answers each request after the chosen number of waits,
  // and toggles mem_ready randomly when nothing is requested.
  task automatic respond();
    int tgt;
    if (mem_req) begin
      tgt       = iord ? wd_g : wf_g;
      mem_ready = (req_cnt >= tgt);
      req_cnt   = mem_ready ? 0 : req_cnt + 1;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [2:0] fn, input logic z,
                          input int wf, input int wd, input int idle);
    bit started;
    int left;
    opcode = op; funct = fn; zero = z;
    wf_g = wf; wd_g = wd; req_cnt = 0;
    model_rc = model_rc + 16'd1;
    exp_q.push_back(model(op, fn, z, wf, wd, model_rc));
    left    = idle;
    run     = (idle == 0);
    started = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      respond();
      tick();
      if (state != 4'd0) started = 1'b1;
      if (left > 0) begin
        left--;
        if (left == 0) run = 1'b1;
      end
      if (started && state == 4'd0) return;
    end
    n_chk++; n_err++;
    $display("FAIL instr_timeout: op %b never returned to FETCH, state %0d", op, state);
  endtask

  logic [3:0] ops [6];
  int         bad;
  int         wf, wd;
  logic [3:0] op;

  initial begin
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b1010, 4'b1100};
    rst = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    opcode = 4'd0; funct = 3'd0; mon_en = 1'b0;
    model_rc = '0; wf_g = 0; wd_g = 0; req_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_retire", 32'(retire_cnt), 32'd0);
    chk("rst_idle_req", 32'(mem_req), 32'd0);
    tick();
    mon_en = 1'b1;

    // Plan cases first, then random mix
    do_instr(4'b0000, 3'b010, 1'b0, 0, 0, 0);
    do_instr(4'b1000, 3'b000, 1'b0, 0, 3, 0);
    do_instr(4'b1100, 3'b000, 1'b1, 0, 0, 0);
    do_instr(4'b1100, 3'b000, 1'b0, 0, 0, 1);
    do_instr(4'b1010, 3'b000, 1'b0, 14, 14, 0);
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      wf = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
      wd = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
      do_instr(op, 3'($urandom), 1'($urandom), wf, wd, int'($urandom_range(0, 2)));
    end
    run = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("retire_total", 32'(retire_cnt), 32'(model_rc));
    mon_en = 1'b0;

    // Reset in the middle of a store: no write, no retire, counter cleared
    opcode = 4'b1010; funct = 3'd0; run = 1'b1; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick(); tick();
    #1;
    chk("mwr_state", 32'(state), 32'd7);
    chk("mwr_req", 32'(mem_req), 32'd1);
    chk("mwr_we", 32'(mem_we), 32'd1);
    rst = 1'b1; mem_ready = 1'b1; run = 1'b0;
    #1;
    chk("rst_mwr_req", 32'(mem_req), 32'd0);
    chk("rst_mwr_we", 32'(mem_we), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mwr_state", 32'(state), 32'd0);
    chk("rst_mwr_retire", 32'(retire_cnt), 32'd0);
    bad = 0;
    repeat (4) begin
      tick();
      if (state !== 4'd0 || mem_req !== 1'b0) bad++;
    end
    chk("run0_hold_cycles", 32'(bad), 32'd0);

    // Illegal opcode traps and stays trapped until reset
    opcode = 4'b0111; run = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    chk("illegal_state", 32'(state), 32'd10);
    chk("illegal_trap", 32'(trap), 32'd1);
    bad = 0;
    repeat (20) begin
      mem_ready = 1'($urandom);
      tick();
      if (state !== 4'd10 || trap !== 1'b1 || mem_req || mem_we || ir_write ||
          pc_en || reg_write || retire_cnt !== '0) bad++;
    end
    chk("trap_sticky_cycles", 32'(bad), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("trap_clr_state", 32'(state), 32'd0);
    chk("trap_clr_flag", 32'(trap), 32'd0);

    // Watchdog: 15 unanswered fetch cycles trap
    opcode = 4'b0000; run = 1'b1; mem_ready = 1'b0;
    repeat (14) tick();
    chk("wd_before_limit", 32'(state), 32'd0);
    chk("wd_req_held", 32'(mem_req), 32'd1);
    tick();
    chk("wd_trap_state", 32'(state), 32'd10);
    chk("wd_trap_flag", 32'(trap), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Ready on the 15th request cycle: completion wins
    repeat (14) tick();
    mem_ready = 1'b1;
    tick();
    chk("wd_edge_state", 32'(state), 32'd1);
    chk("wd_edge_trap", 32'(trap), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle sequencer for the MIPS-16 datapath. It replaces single-cycle decode with a Moore/Mealy FSM that walks each instruction through fetch, decode, execute, memory and writeback, sharing one ALU and one unified memory port. It drives datapath mux selects, write enables and a req/ready memory handshake, and provides a wait-state watchdog, a sticky trap and a retire counter. It sits between the IR opcode/funct fields, the ALU zero flag, and the datapath/memory.

Parameters:
MEM_WAIT_MAX, 15, max consecutive cycles mem_ready may stay low in one memory state before trap (1..255)
RETIRE_W, 16, retire counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
run  input  1  enable for starting a new fetch
opcode  input  4  IR[15:12], stable except when ir_write
funct  input  3  IR[2:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  write qualifier for mem_req
iord  output  1  0: address=PC, 1: address=ALUOut
ir_write  output  1  load IR from memory data
pc_en  output  1  PC load enable
pc_src  output  1  0: ALU result, 1: ALUOut register
alu_src_a  output  1  0: PC, 1: regA
alu_src_b  output  2  00 regB, 01 const 1, 10 sign-ext imm
alu_ctrl  output  3  ALU op (010 add, 110 sub, R-type = funct)
reg_dst  output  1  1: rd, 0: rt
mem_to_reg  output  1  1: MDR, 0: ALUOut
reg_write  output  1  register file write enable
trap  output  1  sticky error flag
state  output  4  current state encoding (debug)
retire_cnt  output  RETIRE_W  instructions completed

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, WB_ALU=9, TRAP=10.
- Reset (rst=1 at edge): state=FETCH, trap=0, retire_cnt=0, wait_cnt=0. While rst=1, every enable and request output is forced to 0. rst mid-instruction aborts it with no writeback.
- Defaults in every state: all enables 0, selects 0, alu_ctrl=010.
- FETCH: if run=0, mem_req=0 and the state holds. If run=1: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01. When mem_ready=1 (Mealy): ir_write=1, pc_en=1, pc_src=0, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, alu_ctrl=010 (branch target into ALUOut). Next state by opcode: 0000 goes to EXEC_R; 0001 and 0010 go to EXEC_I; 1000 and 1010 go to MEM_ADDR; 1100 goes to BRANCH; any other opcode goes to TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctrl=funct. Next WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_ctrl=010 for 0001, 110 for 0010. Next WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=(opcode==0000). Retire, next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=010. Next MEM_RD for 1000, MEM_WR for 1010.
- MEM_RD: mem_req=1, iord=1. On mem_ready, next MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Retire, next FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready, retire and go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=1, pc_en=zero (combinational). Retire, next FETCH.
- TRAP: trap=1 and all enables 0. Left only by rst.
- Timing: ALU op 4 cycles, lw 5, sw 4, beq 3, each plus memory wait states.
- Handshake: mem_req stays high until the cycle mem_ready=1, and drops the next cycle unless the next state also requests. mem_ready outside a requesting state is ignored.
- Watchdog: wait_cnt clears on entry to FETCH/MEM_RD/MEM_WR and increments each requesting cycle with mem_ready=0. When it reaches MEM_WAIT_MAX, the next state is TRAP. If mem_ready=1 in the same cycle as the limit, completion wins. In FETCH with run=0 there is no request and no count.
- Retire: retire_cnt+1 on the completion cycle of each instruction. Wraps from all-ones to 0. Never increments in TRAP.

Test Plan:
- Reset then run=1, mem_ready always 1, IR=0000 funct 010 -> states 0,1,2,9,0; reg_write=1 with reg_dst=1 only in state 9; retire_cnt=1 after 4 cycles.
- lw (1000) with mem_ready delayed 3 cycles in MEM_RD -> mem_req high 4 cycles, iord=1, then MEM_WB with mem_to_reg=1, reg_write=1; total 8 cycles.
- beq (1100) with zero=1, then with zero=0 -> pc_en=1 and pc_src=1 in BRANCH, then pc_en=0; both take 3 cycles and retire.
- Opcode 0111 -> DECODE to TRAP; trap=1 sticky; no enables for 20 cycles; rst returns state=0, trap=0.
- MEM_WAIT_MAX=15, mem_ready held 0 in FETCH -> TRAP after 15 request cycles; repeat with mem_ready=1 on cycle 15 -> DECODE, no trap.
- rst asserted during MEM_WR -> outputs 0 that cycle, no write, state=FETCH, retire_cnt=0; run=0 -> FETCH holds with mem_req=0.
